// File: rtl/fetch_unit_pkg.sv
// Purpose: shared constants for the IF stage (no-op encoding, fetch FSM states).
// Latency: n/a (constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // Reserved opcode-15 encoding that the decoder treats as a no-op.
  localparam logic [15:0] INST_NOP = 16'hF01D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // one cycle after reset before the first request
    S_REQ  = 2'd1,  // request to pc outstanding
    S_FULL = 2'd2,  // fetched word parked in the fetch buffer, no request
    S_DROP = 2'd3   // stale request outstanding, its response is discarded
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// Purpose: IF/ID pipeline register (IR, PC+1, valid) with load, squash-to-NOP and hold.
// Latency: 1 cycle from load to outputs.
// Backpressure: load=0 holds the register unchanged.
//
// Ports:
//   clk, reset_n       clock, async active-low reset
//   load               register is written this cycle
//   word_vld           a real fetched word is being consumed (else NOP is loaded)
//   squash             consumed word is replaced by NOP and marked invalid
//   word, pc_next      fetched instruction and its PC+1
//   ir, pc, valid      IF/ID contents
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            word_vld,
  input  logic            squash,
  input  logic [WORD-1:0] word,
  input  logic [WORD-1:0] pc_next,
  output logic [WORD-1:0] ir,
  output logic [WORD-1:0] pc,
  output logic            valid
);

  localparam logic [WORD-1:0] NOP = WORD'(INST_NOP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir    <= NOP;
      pc    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      if (word_vld) begin
        // A squashed word still records its PC+1 so the stream position is kept.
        ir    <= squash ? NOP : word;
        pc    <= pc_next;
        valid <= !squash;
      end else begin
        // Nothing to hand to ID: insert a bubble, leave pc_id as it was.
        ir    <= NOP;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Purpose: IF stage - PC, single-outstanding imem handshake, 1-entry fetch buffer, IF/ID, retired count.
// Latency: 1-cycle memory gives one valid ir_id per cycle; an n-cycle memory adds n-1 bubbles.
// Backpressure: ir_write/pc_write low holds IF/ID and pc; an arriving word parks in the fetch buffer.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   i_readM, i_address                imem request (address stable while i_readM=1)
//   i_data, i_inputReady              imem response
//   pc_write, ir_write, flush_if      hazard unit controls
//   incr_num_inst                     ID instruction retires this cycle (if valid)
//   redirect_valid, redirect_target   taken branch/jump
//   ir_id, pc_id, valid_id            IF/ID register
//   num_inst                          retired-instruction counter
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              WORD     = 16,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            i_readM,
  output logic [WORD-1:0] i_address,
  input  logic [WORD-1:0] i_data,
  input  logic            i_inputReady,
  input  logic            pc_write,
  input  logic            ir_write,
  input  logic            flush_if,
  input  logic            incr_num_inst,
  input  logic            redirect_valid,
  input  logic [WORD-1:0] redirect_target,
  output logic [WORD-1:0] ir_id,
  output logic [WORD-1:0] pc_id,
  output logic            valid_id,
  output logic [WORD-1:0] num_inst
);

  fetch_state_t    state_q;
  logic [WORD-1:0] pc_q;
  logic [WORD-1:0] fbuf_q;
  logic            fbuf_valid_q;

  logic [WORD-1:0] pc_plus1;
  logic            avail;
  logic [WORD-1:0] avail_word;
  logic            consume;

  assign pc_plus1 = pc_q + 1'b1;

  // The buffered word is older than anything on the bus, so it wins.
  assign avail      = fbuf_valid_q || (state_q == S_REQ && i_inputReady);
  assign avail_word = fbuf_valid_q ? fbuf_q : i_data;
  assign consume    = ir_write && pc_write && avail && !redirect_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fbuf_q       <= '0;
      fbuf_valid_q <= 1'b0;
      i_readM      <= 1'b0;
      i_address    <= '0;
      num_inst     <= '0;
    end else begin
      if (incr_num_inst && valid_id) begin
        num_inst <= num_inst + 1'b1;
      end

      if (redirect_valid) begin
        pc_q         <= redirect_target;
        fbuf_valid_q <= 1'b0;
        // A request still waiting on memory cannot change address; let it
        // finish in S_DROP (this also covers a second redirect while dropping).
        if ((state_q == S_REQ || state_q == S_DROP) && !i_inputReady) begin
          state_q <= S_DROP;
        end else begin
          state_q   <= S_REQ;
          i_readM   <= 1'b1;
          i_address <= redirect_target;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q   <= S_REQ;
            i_readM   <= 1'b1;
            i_address <= pc_q;
          end
          S_REQ: begin
            if (i_inputReady) begin
              if (consume) begin
                // Word went straight to IF/ID: issue the next request back-to-back.
                pc_q      <= pc_plus1;
                i_address <= pc_plus1;
              end else begin
                fbuf_q       <= i_data;
                fbuf_valid_q <= 1'b1;
                state_q      <= S_FULL;
                i_readM      <= 1'b0;
              end
            end
          end
          S_FULL: begin
            if (consume) begin
              fbuf_valid_q <= 1'b0;
              pc_q         <= pc_plus1;
              state_q      <= S_REQ;
              i_readM      <= 1'b1;
              i_address    <= pc_plus1;
            end
          end
          S_DROP: begin
            if (i_inputReady) begin
              state_q   <= S_REQ;
              i_address <= pc_q;
            end
          end
        endcase
      end
    end
  end

  fetch_unit_if_id_reg #(.WORD(WORD)) u_if_id (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ir_write || redirect_valid),
    .word_vld (consume),
    .squash   (flush_if),
    .word     (avail_word),
    .pc_next  (pc_plus1),
    .ir       (ir_id),
    .pc       (pc_id),
    .valid    (valid_id)
  );

endmodule
